dmem_serial_responder: RTL and testbench

Byte-serial data-memory responder that serves the processor's data-memory port (address, write enable, byte / half-word size, sign extend, write data) from an 8-bit-wide storage array. It moves one byte per clock under a req/busy/done handshake, so it can replace the single-cycle data memory when the processor is built with stall support. Storage is big-endian and matches the existing data memory's byte image. Benches preload and dump it through the hierarchical `mem` array exactly as with the current data memory.

---
 rtl/dmem_serial_responder.sv | 145 ++++++++++++++
 tb/tb_dmem_serial_responder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_serial_responder.sv
// Byte-serial data-memory responder.
// Big-endian 8-bit storage, one byte moved per clock under req/busy/done.
// Vectors use [0:31] numbering, so bit 0 is the MSB and bit 31 is the LSB.
module dmem_serial_responder #(
  parameter int SIZE = 16384
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic [0:31] addr,
  input  logic [0:31] data_in,
  input  logic        write_enable,
  input  logic        mem_byte,
  input  logic        mem_half_word,
  input  logic        sign_extend,
  output logic [0:31] data_out,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int AW = $clog2(SIZE);

  // state | meaning
  // IDLE  | waiting for req; the only state that samples the request inputs
  // XFER  | moving one byte per edge at ptr, cnt = bytes left minus one
  // DONE  | one-cycle completion pulse (err set if the request was misaligned)
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t        state;
  logic [7:0]    mem [0:SIZE-1];
  logic [AW-1:0] ptr;
  logic [1:0]    cnt;
  logic          is_write;
  logic          is_sext;
  logic          is_byte;
  logic          is_half;
  // Store data leaves from the top byte; load bytes enter at the bottom.
  // Both directions therefore use the same left shift each XFER edge.
  logic [0:31]   shreg;
  logic [7:0]    rd_byte;
  logic          aligned;
  logic [0:31]   st_word;
  logic [0:31]   ld_result;
  logic          unused_hi;

  assign rd_byte   = mem[ptr];
  assign unused_hi = ^addr[0:31-AW];

  // Alignment check and left-justification of store data for the capture edge.
  always_comb begin
    aligned = 1'b1;
    st_word = data_in;
    if (mem_byte) begin
      st_word = {data_in[24:31], 24'h0};
    end else if (mem_half_word) begin
      aligned = ~addr[31];
      st_word = {data_in[16:31], 16'h0};
    end else begin
      aligned = ~(addr[30] | addr[31]);
    end
  end

  // Assemble the load result as the final byte arrives, with optional sign extension.
  always_comb begin
    ld_result = {shreg[8:31], rd_byte};
    if (is_byte) begin
      ld_result = {{24{is_sext & rd_byte[7]}}, rd_byte};
    end else if (is_half) begin
      ld_result = {{16{is_sext & shreg[24]}}, shreg[24:31], rd_byte};
    end
  end

  // Storage write port; no reset so contents survive reset.
  always_ff @(posedge clock) begin
    if (state == XFER && is_write) begin
      mem[ptr] <= shreg[0:7];
    end
  end

  // Access sequencer with registered handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      data_out <= 32'h0;
      ptr      <= '0;
      cnt      <= 2'd0;
      is_write <= 1'b0;
      is_sext  <= 1'b0;
      is_byte  <= 1'b0;
      is_half  <= 1'b0;
      shreg    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            ptr      <= addr[32-AW:31];
            shreg    <= st_word;
            is_write <= write_enable;
            is_sext  <= sign_extend;
            is_byte  <= mem_byte;
            is_half  <= ~mem_byte & mem_half_word;
            cnt      <= mem_byte ? 2'd0 : (mem_half_word ? 2'd1 : 2'd3);
            busy     <= 1'b1;
            if (aligned) begin
              state <= XFER;
            end else begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end
          end
        end
        XFER: begin
          shreg <= {shreg[8:31], rd_byte};
          ptr   <= ptr + AW'(1);
          cnt   <= cnt - 2'd1;
          if (cnt == 2'd0) begin
            state <= DONE;
            done  <= 1'b1;
            if (!is_write) begin
              data_out <= ld_result;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_serial_responder.sv
// Self-checking bench for dmem_serial_responder: directed plan items plus
// randomized accesses against a byte-array reference model.
module tb_dmem_serial_responder;

  localparam int SIZE = 16384;

  logic        clock = 1'b0;
  logic        reset;
  logic        req;
  logic [0:31] addr;
  logic [0:31] data_in;
  logic        write_enable;
  logic        mem_byte;
  logic        mem_half_word;
  logic        sign_extend;
  logic [0:31] data_out;
  logic        busy;
  logic        done;
  logic        err;

  int passed = 0;
  int total  = 0;

  logic [7:0]  mm [0:SIZE-1];
  logic [31:0] model_dout;

  always #5 clock = ~clock;

  dmem_serial_responder #(.SIZE(SIZE)) dut (
    .clock(clock), .reset(reset), .req(req), .addr(addr), .data_in(data_in),
    .write_enable(write_enable), .mem_byte(mem_byte), .mem_half_word(mem_half_word),
    .sign_extend(sign_extend), .data_out(data_out), .busy(busy), .done(done), .err(err)
  );

  function automatic logic [31:0] model_load(int base, int n, bit sx);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < n; i++) v = (v << 8) | {24'h0, mm[base + i]};
    if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic scramble_inputs();
    req           = 1'($urandom);
    addr          = $urandom;
    data_in       = $urandom;
    write_enable  = 1'($urandom);
    mem_byte      = 1'($urandom);
    mem_half_word = 1'($urandom);
    sign_extend   = 1'($urandom);
  endtask

  // One full access: drive, update model, wait for done, check everything.
  task automatic do_access(input logic [31:0] a, input logic [31:0] d, input bit we,
                           input bit b, input bit h, input bit sx, input bit scramble);
    int n, base, wbase, cyc, exp_cyc, bad;
    bit al, seen;
    logic [31:0] got, exp;
    n     = b ? 1 : (h ? 2 : 4);
    al    = b || (h ? (a[0] == 1'b0) : (a[1:0] == 2'b00));
    base  = int'(a % SIZE);
    wbase = base & ~3;
    addr = a; data_in = d; write_enable = we; mem_byte = b;
    mem_half_word = h; sign_extend = sx; req = 1'b1;
    @(posedge clock); #1;
    if (scramble) scramble_inputs(); else req = 1'b0;
    if (al) begin
      if (we) begin
        for (int i = 0; i < n; i++) mm[base + i] = d[8*(n-1-i) +: 8];
      end else begin
        model_dout = model_load(base, n, sx);
      end
    end
    exp_cyc = al ? n + 1 : 1;
    cyc = 0; seen = 0; bad = 0;
    while (!seen && cyc < 12) begin
      @(negedge clock);
      cyc++;
      if (done === 1'b1) seen = 1;
      else begin
        if (busy !== 1'b1 || err !== 1'b0) bad++;
        if (scramble) scramble_inputs();
      end
    end
    total++;
    if (!seen || cyc != exp_cyc)
      $display("FAIL latency addr=%h: done seen=%0d at cycle %0d, required cycle %0d", a, seen, cyc, exp_cyc);
    else passed++;
    total++;
    if (bad != 0) $display("FAIL busy_before_done addr=%h: %0d bad cycles, required 0", a, bad);
    else passed++;
    if (seen) begin
      total++;
      if (busy !== 1'b1 || err !== !al)
        $display("FAIL done_flags addr=%h: busy=%b err=%b, required busy=1 err=%b", a, busy, err, !al);
      else passed++;
      total++;
      if (data_out !== model_dout)
        $display("FAIL data_out addr=%h: got %h, required %h", a, data_out, model_dout);
      else passed++;
      got = 32'h0; exp = 32'h0;
      for (int i = 0; i < 4; i++) begin
        got = (got << 8) | {24'h0, dut.mem[wbase + i]};
        exp = (exp << 8) | {24'h0, mm[wbase + i]};
      end
      total++;
      if (got !== exp) $display("FAIL mem_word addr=%h: got %h, required %h", wbase, got, exp);
      else passed++;
      if (scramble) req = 1'b1;
    end
    @(posedge clock); #1;
    req = 1'b0;
    @(negedge clock);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0)
      $display("FAIL idle_after addr=%h: busy=%b done=%b err=%b, required all 0", a, busy, done, err);
    else passed++;
  endtask

  task automatic test_reset();
    req = 0; addr = 0; data_in = 0; write_enable = 0;
    mem_byte = 0; mem_half_word = 0; sign_extend = 0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || data_out !== 32'h0)
      $display("FAIL reset_async: busy=%b done=%b err=%b data_out=%h, required 0", busy, done, err, data_out);
    else passed++;
    req = 1'b1;
    @(negedge clock); @(negedge clock);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || data_out !== 32'h0)
      $display("FAIL reset_hold: busy=%b done=%b data_out=%h, required 0", busy, done, data_out);
    else passed++;
    req = 1'b0;
    reset = 1'b0;
    model_dout = 32'h0;
    @(negedge clock);
  endtask

  task automatic test_clear();
    for (int a = 0; a < 'h100; a += 4) do_access(a, 0, 1, 0, 0, 0, 0);
    do_access(32'h100, 0, 1, 0, 0, 0, 0);
    do_access(32'h200, 0, 1, 0, 0, 0, 0);
    do_access(32'h3FFC, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic test_directed();
    do_access(32'h100, 32'hDEADBEEF, 1, 0, 0, 0, 0);
    do_access(32'h100, 0, 0, 0, 0, 0, 0);
    total++;
    if (data_out !== 32'hDEADBEEF) $display("FAIL word_load: got %h, required DEADBEEF", data_out);
    else passed++;
    do_access(32'h101, 0, 0, 1, 0, 1, 0);
    total++;
    if (data_out !== 32'hFFFFFFAD) $display("FAIL byte_sx: got %h, required FFFFFFAD", data_out);
    else passed++;
    do_access(32'h101, 0, 0, 1, 0, 0, 0);
    total++;
    if (data_out !== 32'h000000AD) $display("FAIL byte_zx: got %h, required 000000AD", data_out);
    else passed++;
    do_access(32'h103, 0, 0, 1, 0, 1, 0);
    total++;
    if (data_out !== 32'hFFFFFFEF) $display("FAIL byte_sx_103: got %h, required FFFFFFEF", data_out);
    else passed++;
    do_access(32'h102, 0, 0, 0, 1, 1, 0);
    total++;
    if (data_out !== 32'hFFFFBEEF) $display("FAIL half_sx: got %h, required FFFFBEEF", data_out);
    else passed++;
    do_access(32'h100, 32'hAAAA1234, 1, 0, 1, 0, 0);
    do_access(32'h100, 0, 0, 0, 0, 0, 0);
    total++;
    if (data_out !== 32'h1234BEEF) $display("FAIL half_store_word: got %h, required 1234BEEF", data_out);
    else passed++;
  endtask

  task automatic test_misaligned();
    do_access(32'h102, 32'h55667788, 1, 0, 0, 0, 0);
    do_access(32'h101, 0, 0, 0, 1, 1, 0);
    do_access(32'h103, 32'h0000CAFE, 1, 0, 1, 0, 0);
    do_access(32'h101, 0, 0, 0, 0, 0, 0);
    total++;
    if (data_out !== 32'h1234BEEF) $display("FAIL misaligned_keep: got %h, required 1234BEEF", data_out);
    else passed++;
  endtask

  task automatic test_handshake();
    do_access(32'h40, $urandom, 1, 0, 0, 0, 1);
    do_access(32'h40, 0, 0, 0, 0, 0, 1);
    do_access(32'h42, 0, 0, 0, 1, 1, 1);
    do_access(32'h43, $urandom, 1, 1, 0, 0, 1);
    do_access(32'h41, 0, 0, 0, 1, 0, 1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 150; i++) begin
      a = $urandom_range(0, 255);
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_C000);
      do_access(a, $urandom, 1'($urandom), ($urandom_range(0, 2) == 0),
                1'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_req_held();
    int cyc, k;
    logic [31:0] exp;
    exp = model_load(32'h100, 4, 0);
    addr = 32'h100; data_in = 0; write_enable = 0; mem_byte = 0;
    mem_half_word = 0; sign_extend = 0; req = 1'b1;
    cyc = 0; k = 0;
    while (k < 3 && cyc < 30) begin
      @(negedge clock);
      cyc++;
      if (done === 1'b1) begin
        total++;
        if (cyc != 5 + 6 * k || data_out !== exp)
          $display("FAIL req_held pulse %0d: cycle %0d data %h, required cycle %0d data %h",
                   k, cyc, data_out, 5 + 6 * k, exp);
        else passed++;
        k++;
      end
    end
    req = 1'b0;
    model_dout = exp;
    total++;
    if (k != 3) $display("FAIL req_held_count: got %0d pulses, required 3", k);
    else passed++;
    @(negedge clock); @(negedge clock);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL req_held_idle: busy=%b done=%b, required 0", busy, done);
    else passed++;
  endtask

  task automatic test_boundary();
    do_access(32'h3FFC, $urandom | 32'h0000_0080, 1, 0, 0, 0, 0);
    do_access(32'h3FFC, 0, 0, 0, 0, 0, 0);
    do_access(32'h3FFF, 0, 0, 1, 0, 1, 0);
    do_access(32'hABCD_C100, 0, 0, 0, 0, 0, 0);
    total++;
    if (data_out !== 32'h1234BEEF) $display("FAIL alias_load: got %h, required 1234BEEF", data_out);
    else passed++;
  endtask

  task automatic test_mid_reset();
    logic [31:0] got;
    addr = 32'h200; data_in = 32'h11223344; write_enable = 1; mem_byte = 0;
    mem_half_word = 0; sign_extend = 0; req = 1'b1;
    @(posedge clock); #1 req = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || data_out !== 32'h0)
      $display("FAIL mid_reset_outputs: busy=%b done=%b err=%b data_out=%h, required 0", busy, done, err, data_out);
    else passed++;
    mm['h200] = 8'h11; mm['h201] = 8'h22;
    model_dout = 32'h0;
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    got = {dut.mem['h200], dut.mem['h201], dut.mem['h202], dut.mem['h203]};
    total++;
    if (got !== 32'h11220000) $display("FAIL mid_reset_mem: got %h, required 11220000", got);
    else passed++;
    @(negedge clock);
    do_access(32'h201, 0, 0, 1, 0, 0, 0);
    total++;
    if (data_out !== 32'h00000022) $display("FAIL post_reset_load: got %h, required 00000022", data_out);
    else passed++;
  endtask

  initial begin
    for (int i = 0; i < SIZE; i++) mm[i] = 8'h0;
    model_dout = 32'h0;
    test_reset();
    test_clear();
    test_directed();
    test_misaligned();
    test_handshake();
    test_random();
    test_req_held();
    test_boundary();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
